mem_arbiter: RTL

Shares the single RAM port between the two CPUs' caches: dcache0, dcache1, icache0 and icache1. It sits between the per-CPU cache_control_if request lines and the RAM model. The block arbitrates one owner at a time and holds the grant across a dcache two-word block transfer. When one owner finishes, it alternates between the data and instruction classes so neither class starves. It returns `dwait`/`iwait` and load data to the requesters.

---
 rtl/cpu_types_pkg.sv | 26 ++
 rtl/mem_arbiter_rr_pick2.sv | 12 +
 rtl/mem_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake state, word type and arbiter state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } arbstate_t;

    typedef enum logic {
        CLS_D = 1'b0,
        CLS_I = 1'b1
    } class_t;

    localparam int CPUS = 2;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: with both requesting, the index opposite last_i wins.
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       idx_o,
    output logic       vld_o
);

    assign vld_o = |req_i;
    assign idx_o = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for two dcaches and two icaches; locks the grant over a
// dcache block transfer and alternates data/instruction classes between grants.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int BEATS = 2
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [1:0]      dREN,
    input  logic [1:0]      dWEN,
    input  word_t           daddr  [CPUS],
    input  word_t           dstore [CPUS],
    input  logic [1:0]      iREN,
    input  word_t           iaddr  [CPUS],
    output logic [1:0]      dwait,
    output logic [1:0]      iwait,
    output word_t           dload,
    output word_t           iload,
    output logic            ramREN,
    output logic            ramWEN,
    output word_t           ramaddr,
    output word_t           ramstore,
    input  word_t           ramload,
    input  ramstate_t       ramstate
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    arbstate_t       state_q, state_d;
    logic            owner_q, owner_d;
    logic [BW-1:0]   beat_q, beat_d;
    class_t          last_class_q, last_class_d;
    logic            last_didx_q, last_didx_d;
    logic            last_iidx_q, last_iidx_d;

    logic [1:0] dreq;
    logic       d_idx, d_vld, i_idx, i_vld;
    logic       access, own_dreq, own_ireq;

    assign dreq     = dREN | dWEN;
    assign access   = (ramstate == ACCESS);
    assign own_dreq = dreq[owner_q];
    assign own_ireq = iREN[owner_q];
    assign dload    = ramload;
    assign iload    = ramload;

    rr_pick2 u_drr (.req_i(dreq), .last_i(last_didx_q), .idx_o(d_idx), .vld_o(d_vld));
    rr_pick2 u_irr (.req_i(iREN), .last_i(last_iidx_q), .idx_o(i_idx), .vld_o(i_vld));

    // Strobes follow the owner's live inputs; completion is suppressed while reset is high.
    always_comb begin
        dwait    = 2'b11;
        iwait    = 2'b11;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            DGRANT: begin
                ramWEN   = dWEN[owner_q];
                ramREN   = dREN[owner_q] & ~dWEN[owner_q];
                ramaddr  = daddr[owner_q];
                ramstore = dstore[owner_q];
                if (access && own_dreq && !RST) dwait[owner_q] = 1'b0;
            end
            IGRANT: begin
                ramREN  = iREN[owner_q];
                ramaddr = iaddr[owner_q];
                if (access && own_ireq && !RST) iwait[owner_q] = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        beat_d       = beat_q;
        last_class_d = last_class_q;
        last_didx_d  = last_didx_q;
        last_iidx_d  = last_iidx_q;
        case (state_q)
            ARB: begin
                beat_d = '0;
                if (d_vld && (!i_vld || last_class_q == CLS_I)) begin
                    state_d = DGRANT;
                    owner_d = d_idx;
                end else if (i_vld) begin
                    state_d = IGRANT;
                    owner_d = i_idx;
                end
            end
            DGRANT: begin
                if (own_dreq && access && (int'(beat_q) + 1 < BEATS)) begin
                    beat_d = beat_q + BW'(1);
                end else if (!own_dreq || access) begin
                    state_d      = ARB;
                    beat_d       = '0;
                    last_class_d = CLS_D;
                    last_didx_d  = owner_q;
                end
            end
            IGRANT: begin
                if (!own_ireq || access) begin
                    state_d      = ARB;
                    last_class_d = CLS_I;
                    last_iidx_d  = owner_q;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ARB;
            owner_q      <= 1'b0;
            beat_q       <= '0;
            last_class_q <= CLS_I;
            last_didx_q  <= 1'b1;
            last_iidx_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            beat_q       <= beat_d;
            last_class_q <= last_class_d;
            last_didx_q  <= last_didx_d;
            last_iidx_q  <= last_iidx_d;
        end
    end

endmodule
